// File: rtl/regfile_sequencer.sv
// Command sequencer driving an external 16x8 register file: WRITE, COPY, SWAP and CLEAR
// operations decoded from a small FSM over latched command fields.
module regfile_sequencer #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmdValid,
   output logic              cmdReady,
   input  logic [1:0]        cmdOp,
   input  logic [3:0]        cmdDst,
   input  logic [3:0]        cmdSrc,
   input  logic [DATA_W-1:0] cmdData,
   output logic              busy,
   output logic              done,
   output logic              rfWriteEnable,
   output logic [3:0]        rfWriteAddress,
   output logic [DATA_W-1:0] rfWriteData,
   output logic [3:0]        rfReadAddress1,
   output logic [3:0]        rfReadAddress2,
   input  logic [DATA_W-1:0] rfReadData1,
   input  logic [DATA_W-1:0] rfReadData2
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      SWAP2 = 2'd2,
      CLEAR = 2'd3
   } state_t;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_COPY  = 2'b01;
   localparam logic [1:0] OP_SWAP  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   state_t              state, state_next;
   logic [1:0]          op_q;
   logic [3:0]          dst_q;
   logic [3:0]          src_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   temp_q;
   logic [3:0]          clr_cnt;
   logic                accept;
   logic                swap_two_step;

   assign cmdReady      = (state == IDLE);
   assign busy          = (state != IDLE);
   assign accept        = cmdValid && cmdReady;
   assign swap_two_step = (op_q == OP_SWAP) && (src_q != dst_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         op_q    <= '0;
         dst_q   <= '0;
         src_q   <= '0;
         data_q  <= '0;
         temp_q  <= '0;
         clr_cnt <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_q    <= cmdOp;
            dst_q   <= cmdDst;
            src_q   <= cmdSrc;
            data_q  <= cmdData;
            clr_cnt <= '0;
         end
         // Old dst value is captured on the same edge that overwrites dst with src.
         if (state == EXEC && swap_two_step)
            temp_q <= rfReadData2;
         if (state == CLEAR && clr_cnt != 4'd15)
            clr_cnt <= clr_cnt + 4'd1;
      end
   end

   always_comb begin
      state_next     = state;
      done           = 1'b0;
      rfWriteEnable  = 1'b0;
      rfWriteAddress = '0;
      rfWriteData    = '0;
      rfReadAddress1 = '0;
      rfReadAddress2 = '0;
      case (state)
         IDLE: begin
            if (cmdValid)
               state_next = (cmdOp == OP_CLEAR) ? CLEAR : EXEC;
         end
         EXEC: begin
            state_next = IDLE;
            case (op_q)
               OP_WRITE: begin
                  rfWriteEnable  = 1'b1;
                  rfWriteAddress = dst_q;
                  rfWriteData    = data_q;
                  done           = 1'b1;
               end
               OP_COPY: begin
                  rfReadAddress1 = src_q;
                  rfWriteEnable  = 1'b1;
                  rfWriteAddress = dst_q;
                  rfWriteData    = rfReadData1;
                  done           = 1'b1;
               end
               OP_SWAP: begin
                  rfReadAddress1 = src_q;
                  rfReadAddress2 = dst_q;
                  rfWriteEnable  = 1'b1;
                  rfWriteAddress = dst_q;
                  rfWriteData    = rfReadData1;
                  if (swap_two_step)
                     state_next = SWAP2;
                  else
                     done = 1'b1;
               end
               default: state_next = IDLE;
            endcase
         end
         SWAP2: begin
            rfWriteEnable  = 1'b1;
            rfWriteAddress = src_q;
            rfWriteData    = temp_q;
            done           = 1'b1;
            state_next     = IDLE;
         end
         CLEAR: begin
            rfWriteEnable  = 1'b1;
            rfWriteAddress = clr_cnt;
            rfWriteData    = '0;
            if (clr_cnt == 4'd15) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 16x8 register file attached.
module tb_regfile_sequencer;

   logic       clk;
   logic       reset;
   logic       cmdValid;
   logic       cmdReady;
   logic [1:0] cmdOp;
   logic [3:0] cmdDst;
   logic [3:0] cmdSrc;
   logic [7:0] cmdData;
   logic       busy;
   logic       done;
   logic       rfWriteEnable;
   logic [3:0] rfWriteAddress;
   logic [7:0] rfWriteData;
   logic [3:0] rfReadAddress1;
   logic [3:0] rfReadAddress2;
   logic [7:0] rfReadData1;
   logic [7:0] rfReadData2;

   logic [7:0] rf [16];

   int total = 0;
   int bad   = 0;

   regfile_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .cmdValid      (cmdValid),
      .cmdReady      (cmdReady),
      .cmdOp         (cmdOp),
      .cmdDst        (cmdDst),
      .cmdSrc        (cmdSrc),
      .cmdData       (cmdData),
      .busy          (busy),
      .done          (done),
      .rfWriteEnable (rfWriteEnable),
      .rfWriteAddress(rfWriteAddress),
      .rfWriteData   (rfWriteData),
      .rfReadAddress1(rfReadAddress1),
      .rfReadAddress2(rfReadAddress2),
      .rfReadData1   (rfReadData1),
      .rfReadData2   (rfReadData2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (rfWriteEnable)
         rf[rfWriteAddress] <= rfWriteData;

   assign rfReadData1 = rf[rfReadAddress1];
   assign rfReadData2 = rf[rfReadAddress2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a command, waits (bounded) for acceptance, then drops cmdValid.
   task automatic issue(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] src,
                        input logic [7:0] data);
      int waited;
      cmdValid = 1'b1;
      cmdOp    = op;
      cmdDst   = dst;
      cmdSrc   = src;
      cmdData  = data;
      waited   = 0;
      while (!cmdReady && waited < 50) begin
         tick();
         waited++;
      end
      if (waited >= 50) check("accept_timeout", 32'(waited), 32'd0);
      tick();
      cmdValid = 1'b0;
   endtask

   task automatic fill_all(input logic [7:0] val);
      for (int i = 0; i < 16; i++) begin
         issue(2'b00, 4'(i), 4'd0, val);
         tick();
      end
   endtask

   initial begin
      reset    = 1'b0;
      cmdValid = 1'b0;
      cmdOp    = 2'b00;
      cmdDst   = 4'd0;
      cmdSrc   = 4'd0;
      cmdData  = 8'd0;
      #2;
      check("rst_ready", 32'(cmdReady), 32'd1);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_rf",    {rfWriteEnable, rfWriteAddress, rfWriteData, rfReadAddress1, rfReadAddress2}, 32'd0);
      #20;
      reset = 1'b1;
      tick();

      // WRITE R3 <= A5
      issue(2'b00, 4'd3, 4'd0, 8'hA5);
      check("wr_we",   32'(rfWriteEnable), 32'd1);
      check("wr_addr", 32'(rfWriteAddress), 32'd3);
      check("wr_data", 32'(rfWriteData), 32'hA5);
      check("wr_done", 32'(done), 32'd1);
      check("wr_busy", 32'(busy), 32'd1);
      tick();
      check("wr_idle_we",   32'(rfWriteEnable), 32'd0);
      check("wr_idle_done", 32'(done), 32'd0);
      check("wr_r3",        32'(rf[3]), 32'hA5);

      // COPY R7 <= R3
      issue(2'b01, 4'd7, 4'd3, 8'h00);
      check("cp_ra1",  32'(rfReadAddress1), 32'd3);
      check("cp_addr", 32'(rfWriteAddress), 32'd7);
      check("cp_data", 32'(rfWriteData), 32'hA5);
      check("cp_done", 32'(done), 32'd1);
      tick();
      check("cp_r7", 32'(rf[7]), 32'hA5);

      // SWAP R2 <-> R9
      issue(2'b00, 4'd2, 4'd0, 8'h11); tick();
      issue(2'b00, 4'd9, 4'd0, 8'h22); tick();
      issue(2'b10, 4'd9, 4'd2, 8'h00);
      check("sw1_we",   32'(rfWriteEnable), 32'd1);
      check("sw1_addr", 32'(rfWriteAddress), 32'd9);
      check("sw1_data", 32'(rfWriteData), 32'h11);
      check("sw1_done", 32'(done), 32'd0);
      tick();
      check("sw2_we",   32'(rfWriteEnable), 32'd1);
      check("sw2_addr", 32'(rfWriteAddress), 32'd2);
      check("sw2_data", 32'(rfWriteData), 32'h22);
      check("sw2_done", 32'(done), 32'd1);
      tick();
      check("sw_idle_done", 32'(done), 32'd0);
      check("sw_r2", 32'(rf[2]), 32'h22);
      check("sw_r9", 32'(rf[9]), 32'h11);

      // SWAP R5 <-> R5
      issue(2'b00, 4'd5, 4'd0, 8'h3C); tick();
      issue(2'b10, 4'd5, 4'd5, 8'h00);
      check("ss_addr", 32'(rfWriteAddress), 32'd5);
      check("ss_data", 32'(rfWriteData), 32'h3C);
      check("ss_done", 32'(done), 32'd1);
      tick();
      check("ss_busy", 32'(busy), 32'd0);
      check("ss_we",   32'(rfWriteEnable), 32'd0);
      check("ss_r5",   32'(rf[5]), 32'h3C);

      // CLEAR with a WRITE held pending behind it
      fill_all(8'hFF);
      issue(2'b11, 4'd0, 4'd0, 8'h00);
      cmdValid = 1'b1;
      cmdOp    = 2'b00;
      cmdDst   = 4'd4;
      cmdData  = 8'h77;
      for (int i = 0; i < 16; i++) begin
         check("clr_we",    32'(rfWriteEnable), 32'd1);
         check("clr_addr",  32'(rfWriteAddress), 32'(i));
         check("clr_data",  32'(rfWriteData), 32'd0);
         check("clr_done",  32'(done), (i == 15) ? 32'd1 : 32'd0);
         check("clr_busy",  32'(busy), 32'd1);
         check("clr_ready", 32'(cmdReady), 32'd0);
         tick();
      end
      check("clr_end_ready", 32'(cmdReady), 32'd1);
      check("clr_end_done",  32'(done), 32'd0);
      for (int i = 0; i < 16; i++)
         check("clr_rf", 32'(rf[i]), 32'd0);
      tick();
      cmdValid = 1'b0;
      check("pend_we",   32'(rfWriteEnable), 32'd1);
      check("pend_addr", 32'(rfWriteAddress), 32'd4);
      check("pend_data", 32'(rfWriteData), 32'h77);
      check("pend_done", 32'(done), 32'd1);
      tick();
      check("pend_busy", 32'(busy), 32'd0);
      check("pend_r4",   32'(rf[4]), 32'h77);
      tick();
      check("pend_once", 32'(busy), 32'd0);

      // Reset in CLEAR cycle 6
      fill_all(8'hFF);
      issue(2'b11, 4'd0, 4'd0, 8'h00);
      for (int i = 0; i < 6; i++) tick();
      check("abort_addr_pre", 32'(rfWriteAddress), 32'd6);
      reset = 1'b0;
      #1;
      check("abort_we",    32'(rfWriteEnable), 32'd0);
      check("abort_addr",  32'(rfWriteAddress), 32'd0);
      check("abort_done",  32'(done), 32'd0);
      check("abort_busy",  32'(busy), 32'd0);
      check("abort_ready", 32'(cmdReady), 32'd1);
      tick();
      check("abort_done2", 32'(done), 32'd0);
      for (int i = 0; i < 16; i++)
         check("abort_rf", 32'(rf[i]), (i < 6) ? 32'd0 : 32'hFF);
      reset = 1'b1;
      tick();
      issue(2'b00, 4'd6, 4'd0, 8'h5A);
      check("post_addr", 32'(rfWriteAddress), 32'd6);
      check("post_done", 32'(done), 32'd1);
      tick();
      check("post_r6", 32'(rf[6]), 32'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
